// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared encodings for the EX-stage ALU with multiply/divide:
//               ALUctr codes, ALUOp codes, R-type funct codes and the
//               multiply/divide operation type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Internal ALU control word
    typedef logic [3:0] alu_ctrl_t;

    localparam alu_ctrl_t c_ALU_AND  = 4'b0000;
    localparam alu_ctrl_t c_ALU_OR   = 4'b0001;
    localparam alu_ctrl_t c_ALU_ADD  = 4'b0010;
    localparam alu_ctrl_t c_ALU_SLL  = 4'b0011;
    localparam alu_ctrl_t c_ALU_SRL  = 4'b0100;
    localparam alu_ctrl_t c_ALU_SRA  = 4'b0101;
    localparam alu_ctrl_t c_ALU_SUB  = 4'b0110;
    localparam alu_ctrl_t c_ALU_XOR  = 4'b1000;
    localparam alu_ctrl_t c_ALU_SLT  = 4'b1010;
    localparam alu_ctrl_t c_ALU_SLTU = 4'b1011;
    localparam alu_ctrl_t c_ALU_NOR  = 4'b1100;
    localparam alu_ctrl_t c_ALU_MFHI = 4'b1101;
    localparam alu_ctrl_t c_ALU_MFLO = 4'b1110;
    localparam alu_ctrl_t c_ALU_INV  = 4'b1111;

    // ALUOp from the main decoder
    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] c_ALUOP_ILL   = 2'b11;

    // R-type function codes
    localparam logic [5:0] c_F_SLL   = 6'b000000;
    localparam logic [5:0] c_F_SRL   = 6'b000010;
    localparam logic [5:0] c_F_SRA   = 6'b000011;
    localparam logic [5:0] c_F_SLLV  = 6'b000100;
    localparam logic [5:0] c_F_SRLV  = 6'b000110;
    localparam logic [5:0] c_F_SRAV  = 6'b000111;
    localparam logic [5:0] c_F_MFHI  = 6'b010000;
    localparam logic [5:0] c_F_MFLO  = 6'b010010;
    localparam logic [5:0] c_F_MULT  = 6'b011000;
    localparam logic [5:0] c_F_MULTU = 6'b011001;
    localparam logic [5:0] c_F_DIV   = 6'b011010;
    localparam logic [5:0] c_F_DIVU  = 6'b011011;
    localparam logic [5:0] c_F_ADD   = 6'b100000;
    localparam logic [5:0] c_F_ADDU  = 6'b100001;
    localparam logic [5:0] c_F_SUB   = 6'b100010;
    localparam logic [5:0] c_F_SUBU  = 6'b100011;
    localparam logic [5:0] c_F_AND   = 6'b100100;
    localparam logic [5:0] c_F_OR    = 6'b100101;
    localparam logic [5:0] c_F_XOR   = 6'b100110;
    localparam logic [5:0] c_F_NOR   = 6'b100111;
    localparam logic [5:0] c_F_SLT   = 6'b101010;
    localparam logic [5:0] c_F_SLTU  = 6'b101011;

    // Multiply/divide operation
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

endpackage
`default_nettype wire

// File: rtl/alu_md_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_md_iter
// Description : Iterative multiply/divide engine. One shift-add (multiply)
//               or restoring-subtract (divide) step per cycle on operand
//               magnitudes, sign fix-up on the final cycle.
//               Latency: start edge, WIDTH step edges, one completion edge.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_kill        - abandon any operation in progress
//               i_start       - begin i_op on i_a, i_b (ignored while busy)
//               o_done        - combinational; high in the cycle before the
//                               completion edge, with o_hi_out/o_lo_out valid
//               o_busy        - operation in progress
// Revision    : 1.0 - initial release
// ============================================================================
module alu_md_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_kill,
    input  logic             i_start,
    input  md_op_t           i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi_out,
    output logic [WIDTH-1:0] o_lo_out,
    output logic             o_busy
);

    localparam int            CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;       // partial product high half / remainder
    logic [WIDTH-1:0] r_lo;       // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0] r_opnd;     // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] r_a_orig;   // raw dividend, returned as HI on divide-by-zero
    logic             r_is_div;
    logic             r_neg_q;    // negate product / quotient
    logic             r_neg_r;    // negate remainder
    logic             r_div_zero;

    // Operand preparation
    logic             w_signed;
    logic             w_is_div;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
    assign w_is_div = (i_op == MD_DIV)  || (i_op == MD_DIVU);
    assign w_mag_a  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mag_b  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // Multiply step: conditionally add, then shift {carry, hi, lo} right
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_add;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;

    assign w_sum    = {1'b0, r_hi} + {1'b0, r_opnd};
    assign w_add    = r_lo[0] ? w_sum : {1'b0, r_hi};
    assign w_mul_hi = w_add[WIDTH:1];
    assign w_mul_lo = {w_add[0], r_lo[WIDTH-1:1]};

    // Divide step: shift remainder left taking the next dividend bit, and
    // subtract the divisor when it fits. The shifted remainder is below
    // twice the divisor, so the difference always fits in WIDTH bits.
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_opnd});
    assign w_diff   = w_shift[WIDTH-1:0] - r_opnd;
    assign w_div_hi = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_div_lo = {r_lo[WIDTH-2:0], w_ge};

    // Final sign fix-up
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quot     = r_neg_q ? -r_lo : r_lo;
    assign w_rem      = r_neg_r ? -r_hi : r_hi;

    always_comb begin
        o_hi_out = w_prod_fix[2*WIDTH-1:WIDTH];
        o_lo_out = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            if (r_div_zero) begin
                o_hi_out = r_a_orig;
                o_lo_out = '1;
            end else begin
                o_hi_out = w_rem;
                o_lo_out = w_quot;
            end
        end
    end

    assign o_done = r_busy && (r_cnt == c_LAST);
    assign o_busy = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opnd     <= '0;
            r_a_orig   <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (i_kill) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start && !r_busy) begin
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_a_orig   <= i_a;
            r_is_div   <= w_is_div;
            r_neg_q    <= w_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r    <= w_signed && w_is_div && i_a[WIDTH-1];
            r_div_zero <= w_is_div && (i_b == '0);
            if (w_is_div) begin
                r_lo   <= w_mag_a;
                r_opnd <= w_mag_b;
            end else begin
                r_lo   <= w_mag_b;
                r_opnd <= w_mag_a;
            end
        end else if (r_busy) begin
            if (r_cnt == c_LAST) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
                if (r_is_div) begin
                    r_hi <= w_div_hi;
                    r_lo <= w_div_lo;
                end else begin
                    r_hi <= w_mul_hi;
                    r_lo <= w_mul_lo;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_md.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_md
// Description : EX-stage ALU. Decodes ALUOp/funct, executes single-cycle
//               operations into a registered result, and drives the
//               iterative multiply/divide engine that writes HI/LO.
// Ports       : clk, rst                 - clock, sync active-high reset
//               flush                    - kill accepted / in-flight op
//               in_valid / in_ready      - ID/EX handshake (ready = !busy)
//               alu_op, funct            - operation select
//               op_a, op_b, shamt        - operands
//               out_valid                - one-cycle result pulse
//               out_result, out_illegal  - registered result / illegal flag
//               busy                     - multiply/divide in progress
//               hi, lo                   - architectural HI/LO
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_md
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic             out_illegal,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic             r_out_illegal;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    alu_ctrl_t w_ctrl;
    logic      w_is_md;
    md_op_t    w_md_op;
    logic      w_var_shift;   // shift amount taken from op_a instead of shamt
    logic      w_illegal;

    always_comb begin
        w_ctrl      = c_ALU_INV;
        w_is_md     = 1'b0;
        w_md_op     = MD_MULT;
        w_var_shift = 1'b0;
        case (alu_op)
            c_ALUOP_ADD: w_ctrl = c_ALU_ADD;
            c_ALUOP_SUB: w_ctrl = c_ALU_SUB;
            c_ALUOP_RTYPE: begin
                case (funct)
                    c_F_ADD, c_F_ADDU: w_ctrl = c_ALU_ADD;
                    c_F_SUB, c_F_SUBU: w_ctrl = c_ALU_SUB;
                    c_F_AND:  w_ctrl = c_ALU_AND;
                    c_F_OR:   w_ctrl = c_ALU_OR;
                    c_F_XOR:  w_ctrl = c_ALU_XOR;
                    c_F_NOR:  w_ctrl = c_ALU_NOR;
                    c_F_SLT:  w_ctrl = c_ALU_SLT;
                    c_F_SLTU: w_ctrl = c_ALU_SLTU;
                    c_F_SLL:  w_ctrl = c_ALU_SLL;
                    c_F_SRL:  w_ctrl = c_ALU_SRL;
                    c_F_SRA:  w_ctrl = c_ALU_SRA;
                    c_F_SLLV: begin w_ctrl = c_ALU_SLL; w_var_shift = 1'b1; end
                    c_F_SRLV: begin w_ctrl = c_ALU_SRL; w_var_shift = 1'b1; end
                    c_F_SRAV: begin w_ctrl = c_ALU_SRA; w_var_shift = 1'b1; end
                    c_F_MFHI: w_ctrl = c_ALU_MFHI;
                    c_F_MFLO: w_ctrl = c_ALU_MFLO;
                    c_F_MULT:  begin w_is_md = 1'b1; w_md_op = MD_MULT;  end
                    c_F_MULTU: begin w_is_md = 1'b1; w_md_op = MD_MULTU; end
                    c_F_DIV:   begin w_is_md = 1'b1; w_md_op = MD_DIV;   end
                    c_F_DIVU:  begin w_is_md = 1'b1; w_md_op = MD_DIVU;  end
                    default:   w_ctrl = c_ALU_INV;
                endcase
            end
            default: w_ctrl = c_ALU_INV;
        endcase
    end

    // Multiply/divide decode leaves the control word at INV, so they are
    // excluded explicitly.
    assign w_illegal = (w_ctrl == c_ALU_INV) && !w_is_md;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu_res;

    assign w_shamt = w_var_shift ? op_a[SHW-1:0] : shamt;

    always_comb begin
        w_alu_res = '0;
        case (w_ctrl)
            c_ALU_AND:  w_alu_res = op_a & op_b;
            c_ALU_OR:   w_alu_res = op_a | op_b;
            c_ALU_ADD:  w_alu_res = op_a + op_b;
            c_ALU_SUB:  w_alu_res = op_a - op_b;
            c_ALU_XOR:  w_alu_res = op_a ^ op_b;
            c_ALU_NOR:  w_alu_res = ~(op_a | op_b);
            c_ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            c_ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            c_ALU_SLL:  w_alu_res = op_b << w_shamt;
            c_ALU_SRL:  w_alu_res = op_b >> w_shamt;
            c_ALU_SRA:  w_alu_res = $signed(op_b) >>> w_shamt;
            c_ALU_MFHI: w_alu_res = r_hi;
            c_ALU_MFLO: w_alu_res = r_lo;
            default:    w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiply/divide engine
    // ------------------------------------------------------------------
    logic             w_accept;
    logic             w_md_busy;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_lo;

    assign in_ready = !w_md_busy;
    assign w_accept = in_valid && in_ready && !flush;

    alu_md_iter #(
        .WIDTH (WIDTH)
    ) u_md (
        .clk      (clk),
        .rst      (rst),
        .i_kill   (flush),
        .i_start  (w_accept && w_is_md),
        .i_op     (w_md_op),
        .i_a      (op_a),
        .i_b      (op_b),
        .o_done   (w_md_done),
        .o_hi_out (w_md_hi),
        .o_lo_out (w_md_lo),
        .o_busy   (w_md_busy)
    );

    // ------------------------------------------------------------------
    // Output and HI/LO registers. Completion and a new accept cannot
    // coincide because nothing is accepted while the engine is busy.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_illegal <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_md_done && !flush) begin
                r_hi          <= w_md_hi;
                r_lo          <= w_md_lo;
                r_out_valid   <= 1'b1;
                r_out_result  <= '0;
                r_out_illegal <= 1'b0;
            end else if (w_accept && !w_is_md) begin
                r_out_valid   <= 1'b1;
                r_out_result  <= w_illegal ? '0 : w_alu_res;
                r_out_illegal <= w_illegal;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_illegal = r_out_illegal;
    assign busy        = w_md_busy;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: doc/alu_exec_md.md
Name: alu_exec_md

Overview:
- Parametrised successor to the pipeline's ALU control decoder: decodes ALUOp/funct, executes the operation, and registers the result into EX/MEM.
- Adds shifts, NOR, SLTU and an illegal-op flag.
- Adds a multi-cycle iterative multiply/divide unit that writes the HI/LO registers, with a ready/stall handshake back to the hazard unit.
- Sits in the EX stage between the ID/EX register and the EX/MEM register.

Parameters:
- WIDTH, 32: datapath width; must be a power of two, ≥8.
- SHW, $clog2(WIDTH): shift-amount width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; kills the accepted/in-flight op.
- in_valid  in  1  ID/EX presents an op.
- in_ready  out  1  block can accept; equals !busy.
- alu_op  in  2  00 = ADD, 01 = SUB, 10 = R-type (decode funct), 11 = illegal.
- funct  in  6  R-type function code.
- op_a  in  WIDTH  rs value.
- op_b  in  WIDTH  rt value or immediate.
- shamt  in  SHW  immediate shift amount.
- out_valid  out  1  registered one-cycle pulse: result/flag valid.
- out_result  out  WIDTH  registered result.
- out_illegal  out  1  registered; op was undecodable.
- busy  out  1  mult/div in progress.
- hi, lo  out  WIDTH  architectural HI/LO registers.

Behaviour:
- Reset: out_valid = 0, out_result = 0, out_illegal = 0, busy = 0, hi = 0, lo = 0, and the iteration counter = 0.
- Accept: an op is accepted when in_valid && in_ready && !flush.
- Internal ALUctr encoding:
  - Retained codes: AND 0000, OR 0001, ADD 0010, SUB 0110, XOR 1000, SLT 1010, invalid 1111.
  - New codes: SLL 0011, SRL 0100, SRA 0101, SLTU 1011, NOR 1100, MFHI 1101, MFLO 1110.
- funct decode:
  - Arithmetic/logic: 100000/100001 → ADD; 100010/100011 → SUB; 100100 → AND; 100101 → OR; 100110 → XOR; 100111 → NOR; 101010 → SLT; 101011 → SLTU.
  - Shifts: 000000/000010/000011 → SLL/SRL/SRA of op_b by shamt; 000100/000110/000111 → same shifts by op_a[SHW-1:0].
  - HI/LO reads: 010000 → MFHI; 010010 → MFLO.
  - Mult/div: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
  - Any other funct → illegal.
- Single-cycle ops:
  - out_valid = 1 on the edge after accept; latency is 1.
  - Arithmetic wraps modulo 2^WIDTH; there is no overflow trap.
  - SLT/SLTU produce 0 or 1, zero-extended.
- Illegal op: out_valid = 1, out_illegal = 1, out_result = 0.
- Mult/div ops:
  - Accept at edge E0. busy = 1 from E0 until edge E0+WIDTH+1, i.e. WIDTH+1 busy cycles.
  - One shift-add (multiply) or restoring-subtract (divide) step per cycle, on magnitudes.
  - Sign fix is applied on the final cycle.
  - At E0+WIDTH+1: hi/lo are written, busy = 0, and out_valid pulses with out_result = 0 (no GPR write).
  - Mult: {hi, lo} = 2·WIDTH-bit product.
  - Div: lo = quotient truncated toward zero; hi = remainder with the sign of op_a.
- Divide by zero: hi = op_a, lo = all ones; the full latency still applies.
- Signed overflow (most-negative ÷ −1): lo = most-negative, hi = 0.
- While busy:
  - in_ready = 0, so MFHI/MFLO and all other ops stall upstream.
  - in_valid is ignored and no out_valid is produced.
- MFHI/MFLO issued on the cycle busy falls: they see the new hi/lo.
- flush:
  - Flush on the accept cycle → op not accepted.
  - Flush during busy → busy = 0 and counter = 0 on the next edge; hi/lo unchanged; no out_valid.
  - Flush on the completion edge → hi/lo not written, out_valid = 0.
- rst mid-operation overrides flush and returns every register to its reset value.
- out_valid is a pulse: it returns to 0 on the next edge unless another op completes.

Decomposition:
- Package alu_pkg holds:
  - ALUctr encodings, a 4-bit alu_ctrl_t.
  - ALUOp codes.
  - funct constants.
  - md_op_t enum: MULT, MULTU, DIV, DIVU.
- Sub-module alu_md_iter holds the iterative mul/div engine: counter, partial product/remainder, sign fix.
  - Interface: start, op, a, b → done, hi_out, lo_out, busy.
  - Top level owns decode, the single-cycle ALU, hi/lo and flush.

Test Plan (all at WIDTH = 32):
- ADD: alu_op = 00, op_a = 0xFFFFFFFF, op_b = 1 → next cycle out_valid = 1, out_result = 0x00000000, out_illegal = 0.
- SLT vs SLTU: R-type SLT with op_a = 0xFFFFFFFF, op_b = 1 → 1; SLTU with the same operands → 0.
- SRA: funct 000011, op_b = 0x80000000, shamt = 4 → 0xF8000000. SRLV with op_a = 36 (uses 4) → 0x08000000.
- DIV: op_a = −7, op_b = 2 → busy for 33 cycles; then lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1). An MFLO held at in_valid stalls, then returns 0xFFFFFFFD.
- MULTU: 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. DIVU by 0 → lo = 0xFFFFFFFF, hi = op_a.
- Flush at cycle 10 of a MULT: busy drops next edge, hi/lo keep prior values, no out_valid. Illegal funct 111111 → out_illegal = 1, result 0.
